cola_dispense_ctrl: RTL

COLA_DISPENSE_CTRL -- requirements
Module: cola_dispense_ctrl

---
 rtl/cola_dispense_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/cola_dispense_ctrl.sv
// Cola dispense controller: queues "cola earned" pulses (up to 7) and runs
// the dispense motor for MOTOR_CNT cycles per cola, followed by a GAP_CNT
// cycle motor-off pause. All outputs are registered.
module cola_dispense_ctrl #(
   parameter int unsigned MOTOR_CNT = 50,
   parameter int unsigned GAP_CNT   = 10
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pi_cola,
   output logic       po_motor,
   output logic       po_busy,
   output logic [2:0] po_pend_cnt,
   output logic       po_done,
   output logic       po_drop
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP
   } state_t;

   // Counter loads are one less than the duration: the load edge itself
   // starts the first cycle, and the phase ends on the edge that sees zero.
   localparam logic [15:0] MOTOR_LOAD = 16'(MOTOR_CNT - 1);
   localparam logic [15:0] GAP_LOAD   = 16'(GAP_CNT - 1);

   state_t      state;
   logic [15:0] cnt;
   logic        cnt_zero;
   logic        run_entry;
   logic        accept;
   logic [2:0]  pend_next;

   // Next-edge decisions: RUN entry, queue acceptance and the new queue depth
   always_comb begin
      cnt_zero  = (cnt == '0);
      run_entry = 1'b0;
      case (state)
         IDLE:    run_entry = (po_pend_cnt != '0);
         GAP:     run_entry = cnt_zero && (po_pend_cnt != '0);
         default: run_entry = 1'b0;
      endcase
      // A full queue still accepts a cola if a slot frees on the same edge
      accept    = pi_cola && ((po_pend_cnt != 3'd7) || run_entry);
      pend_next = po_pend_cnt;
      if (accept && !run_entry) begin
         pend_next = po_pend_cnt + 3'd1;
      end else if (!accept && run_entry) begin
         pend_next = po_pend_cnt - 3'd1;
      end
   end

   // Dispense FSM with shared phase counter and registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         po_motor    <= 1'b0;
         po_busy     <= 1'b0;
         po_pend_cnt <= '0;
         po_done     <= 1'b0;
         po_drop     <= 1'b0;
      end else begin
         po_done     <= 1'b0;
         po_drop     <= pi_cola && !accept;
         po_pend_cnt <= pend_next;
         case (state)
            IDLE: begin
               if (run_entry) begin
                  state    <= RUN;
                  cnt      <= MOTOR_LOAD;
                  po_motor <= 1'b1;
                  po_busy  <= 1'b1;
               end
            end
            RUN: begin
               if (cnt_zero) begin
                  state    <= GAP;
                  cnt      <= GAP_LOAD;
                  po_motor <= 1'b0;
                  po_done  <= 1'b1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            GAP: begin
               if (cnt_zero) begin
                  if (run_entry) begin
                     state    <= RUN;
                     cnt      <= MOTOR_LOAD;
                     po_motor <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     po_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               po_motor <= 1'b0;
               po_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
